// File: rtl/adder_pkg.sv
// Shared definitions for the adder result path: flag layout, entry type, FIFO states
// and the saturation constants.
package adder_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned DEF_N = 32;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef struct packed {
        logic [DEF_N-1:0] result;
        flags_t           flags;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} fifo_state_e;

    // Largest positive N-bit two's-complement value, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] max_pos(input int unsigned n);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < n - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] max_neg(input int unsigned n);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i == n - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_fifo2.sv
// Generic 2-entry skid FIFO; in_ready depends only on occupancy and reset.
module result_fifo2
    import adder_pkg::*;
#(
    parameter int unsigned W = 36
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    fifo_state_e  r_state;
    fifo_state_e  w_state_d;
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_valid && o_ready;
    assign w_pop  = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StEmpty;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StEmpty: if (w_push) w_state_d = StOne;
            StOne: begin
                if (w_push && !w_pop)      w_state_d = StFull;
                else if (!w_push && w_pop) w_state_d = StEmpty;
            end
            StFull:  if (w_pop) w_state_d = StOne;
            default: w_state_d = StEmpty;
        endcase
    end

    always_comb begin
        o_ready = (r_state != StFull) && !i_rst;
        o_valid = (r_state != StEmpty);
        o_data  = r_mem[r_rptr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
        end
    end

endmodule

// File: rtl/adder_result_stage.sv
// Registered output stage for the skip-carry adder: optional saturation, NZCV flags,
// a 2-entry skid buffer and a saturating overflow counter.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned SAT   = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     sum,
    input  logic             cout,
    input  logic             of,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    localparam logic [MAX_W-1:0] POS_FULL = max_pos(N);
    localparam logic [MAX_W-1:0] NEG_FULL = max_neg(N);
    localparam logic [N-1:0]     SAT_POS  = POS_FULL[N-1:0];
    localparam logic [N-1:0]     SAT_NEG  = NEG_FULL[N-1:0];

    logic [N-1:0]        w_result;
    flags_t              w_flags;
    logic [N+FLAG_W-1:0] w_entry_in;
    logic [N+FLAG_W-1:0] w_entry_out;
    logic                w_push;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_base;
    logic [CNT_W-1:0]    w_cnt_d;

    // A set sign bit on an overflowed sum means two positives wrapped negative.
    always_comb begin
        w_result = sum;
        if ((SAT != 0) && of) w_result = sum[N-1] ? SAT_POS : SAT_NEG;
        w_flags         = '0;
        w_flags[FLAG_N] = w_result[N-1];
        w_flags[FLAG_Z] = (w_result == '0);
        w_flags[FLAG_C] = cout;
        w_flags[FLAG_V] = of;
    end

    assign w_entry_in = {w_result, w_flags};
    assign w_push     = in_valid && in_ready;

    result_fifo2 #(
        .W (N + FLAG_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_entry_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_entry_out)
    );

    assign out_result = w_entry_out[N+FLAG_W-1:FLAG_W];
    assign out_flags  = w_entry_out[FLAG_W-1:0];

    always_comb begin
        w_cnt_base = clr_count ? '0 : r_cnt;
        w_cnt_d    = w_cnt_base;
        if (w_push && of && (w_cnt_base != {CNT_W{1'b1}})) w_cnt_d = w_cnt_base + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_cnt_d;
    end

    assign ovf_count = r_cnt;

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench: a SAT=1 and a SAT=0 instance share stimulus; a monitor pops
// expected entries whenever the head entry is consumed.
module tb_adder_result_stage;

    localparam int unsigned N  = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          cout = 1'b0;
    logic          of = 1'b0;
    logic          out_ready = 1'b1;
    logic          clr_count = 1'b0;
    logic [N-1:0]  sum = '0;

    logic          in_ready1, in_ready0, out_valid1, out_valid0;
    logic [N-1:0]  res1, res0;
    logic [3:0]    flags1, flags0;
    logic [CW-1:0] cnt1, cnt0;

    adder_result_stage #(.N(N), .SAT(1), .CNT_W(CW)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .sum(sum),
        .cout(cout), .of(of), .out_valid(out_valid1), .out_ready(out_ready),
        .out_result(res1), .out_flags(flags1), .ovf_count(cnt1), .clr_count(clr_count)
    );

    adder_result_stage #(.N(N), .SAT(0), .CNT_W(CW)) dut_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .sum(sum),
        .cout(cout), .of(of), .out_valid(out_valid0), .out_ready(out_ready),
        .out_result(res0), .out_flags(flags0), .ovf_count(cnt0), .clr_count(clr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r1;
        logic [3:0]   f1;
        logic [N-1:0] r0;
        logic [3:0]   f0;
    } exp_t;

    exp_t    sb[$];
    int      n_vec = 0;
    int      n_err = 0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_output: got %0h want none", res1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_result_sat", res1, e.r1);
                check("mon_flags_sat", flags1, e.f1);
                check("mon_valid_raw", out_valid0, 1'b1);
                check("mon_result_raw", res0, e.r0);
                check("mon_flags_raw", flags0, e.f0);
            end
        end
    end

    function automatic logic [N-1:0] model_res(input logic [N-1:0] s, input logic o,
                                               input bit sat);
        if (sat && o) return s[N-1] ? 32'h7FFF_FFFF : 32'h8000_0000;
        return s;
    endfunction

    function automatic logic [3:0] model_flags(input logic [N-1:0] r, input logic c,
                                               input logic o);
        return {r[N-1], (r == '0), c, o};
    endfunction

    task automatic send(input logic [N-1:0] s, input logic c, input logic o, input logic clr,
                        input logic [N-1:0] r1, input logic [3:0] f1,
                        input logic [N-1:0] r0, input logic [3:0] f0);
        bit ok;
        exp_t e;
        ok = 0;
        sum = s; cout = c; of = o; clr_count = clr; in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready1) begin
                e.r1 = r1; e.f1 = f1; e.r0 = r0; e.f0 = f0;
                sb.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; clr_count = 1'b0;
        sum = 32'hDEAD_BEEF; cout = 1'b0; of = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 want 1 within 20 cycles");
        end else begin
            if (clr) exp_cnt = '0;
            if (o && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    task automatic send_m(input logic [N-1:0] s, input logic c, input logic o, input logic clr);
        logic [N-1:0] r1, r0;
        r1 = model_res(s, o, 1'b1);
        r0 = model_res(s, o, 1'b0);
        send(s, c, o, clr, r1, model_flags(r1, c, o), r0, model_flags(r0, c, o));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        idle(3);
        @(negedge clk);
        check("rst_in_ready", in_ready1, 1'b0);
        check("rst_out_valid", out_valid1, 1'b0);
        check("rst_result", res1, 32'h0);
        check("rst_flags", flags1, 4'h0);
        check("rst_count", cnt1, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready1, 1'b1);
        @(posedge clk); #1;

        // Directed arithmetic vectors
        send(32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0110, 32'h0, 4'b0110);
        check("lat_valid", out_valid1, 1'b1);
        check("lat_result", res1, 32'h0);
        send(32'h8000_0001, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b0001, 32'h8000_0001, 4'b1001);
        check("cnt_after_pos_ovf", cnt1, 16'd1);
        send(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 4'b1011, 32'h7FFF_FFFF, 4'b0011);
        check("cnt_after_neg_ovf", cnt1, 16'd2);
        check("cnt_raw", cnt0, 16'd2);
        idle(2);

        // Back-pressure: two beats absorbed, head held stable
        out_ready = 1'b0;
        send(32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h5, 4'b0000, 32'h5, 4'b0000);
        send(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1010, 32'hFFFF_FFFF, 4'b1010);
        check("bp_in_ready_low", in_ready1, 1'b0);
        check("bp_head_a", res1, 32'h5);
        idle(2);
        check("bp_hold_result", res1, 32'h5);
        check("bp_hold_flags", flags1, 4'b0000);
        check("bp_hold_in_ready", in_ready1, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_a", res1, 32'h5);
        @(negedge clk);
        check("drain_b", res1, 32'hFFFF_FFFF);
        @(negedge clk);
        check("drain_empty", out_valid1, 1'b0);
        @(posedge clk); #1;

        // Streaming: one beat per cycle, one-cycle latency
        for (int i = 0; i < 10; i++) begin
            send_m(32'd100 + 32'(i), 1'b0, 1'b0, 1'b0);
            check("stream_result", res1, 32'd100 + 32'(i));
        end
        idle(2);

        // Overflow counter saturation and clear
        while (exp_cnt != 16'hFFFF) send_m(32'h8000_0000, 1'b0, 1'b1, 1'b0);
        check("cnt_full", cnt1, 16'hFFFF);
        send_m(32'h8000_0000, 1'b0, 1'b1, 1'b0);
        check("cnt_hold", cnt1, 16'hFFFF);
        send_m(32'h0000_0001, 1'b0, 1'b1, 1'b1);
        check("cnt_clr_and_ovf", cnt1, 16'd1);
        clr_count = 1'b1;
        idle(1);
        clr_count = 1'b0;
        exp_cnt = '0;
        check("cnt_clr_only", cnt1, 16'd0);
        send_m(32'h1234_5678, 1'b0, 1'b1, 1'b0);
        check("cnt_reinc", cnt1, 16'd1);
        idle(2);

        // Mid-stream reset discards buffered entries
        out_ready = 1'b0;
        send_m(32'h0000_0003, 1'b0, 1'b0, 1'b0);
        send_m(32'h0000_0004, 1'b0, 1'b1, 1'b0);
        check("pre_rst_full", in_ready1, 1'b0);
        rst = 1'b1;
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready1, 1'b0);
        @(posedge clk); #1;
        check("rst_mid_valid", out_valid1, 1'b0);
        check("rst_mid_count", cnt1, 16'd0);
        check("rst_mid_result", res1, 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check("post_mid_rst_valid", out_valid1, 1'b0);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
